// File: rtl/fib_arbiter.sv
// Round-robin front end sharing one Fibonacci calculator among NREQ requesters.
// Optional WAIT watchdog enabled by defining FIB_ARB_TIMEOUT_EN.
module fib_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*5-1:0] req_n,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [15:0]       rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic              calc_reset,
   output logic              calc_begin,
   output logic [4:0]        calc_input,
   input  logic              calc_done,
   input  logic [15:0]       calc_out
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [4:0]    n_q, n_d;
   logic [15:0]   data_q, data_d;
   logic          err_q, err_d;

`ifdef FIB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   logic          pick_vld;
   logic [IW-1:0] pick_idx;
   logic [4:0]    pick_n;
   logic          n_ok;

   // Search starts one past the last winner so a winner goes to the back.
   always_comb begin
      int cand;
      cand     = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!pick_vld && req_valid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(cand);
         end
      end
   end

   assign pick_n = req_n[int'(pick_idx)*5 +: 5];
   assign n_ok   = (pick_n != 5'd0) && (pick_n <= 5'd24);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= IW'(NREQ - 1);
         n_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         n_q     <= n_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef FIB_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      n_d        = n_q;
      data_d     = data_q;
      err_d      = err_q;
      req_ready  = '0;
      rsp_valid  = '0;
      calc_begin = 1'b0;
      calc_input = '0;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld && !reset) begin
               req_ready[pick_idx] = 1'b1;
               owner_d = pick_idx;
               last_d  = pick_idx;
               n_d     = pick_n;
               if (n_ok) begin
                  state_d = S_CLEAR;
               end else begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_CLEAR: begin
            calc_input = n_q;
            state_d    = S_START;
         end
         S_START: begin
            calc_begin = 1'b1;
            calc_input = n_q;
            state_d    = S_WAIT;
`ifdef FIB_ARB_TIMEOUT_EN
            cnt_d      = '0;
`endif
         end
         S_WAIT: begin
            calc_input = n_q;
            if (calc_done) begin
               data_d  = calc_out;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
`ifdef FIB_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         S_RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign calc_reset = reset | (state_q == S_CLEAR);
   assign busy       = (state_q != S_IDLE);
   assign rsp_data   = data_q;
   assign rsp_err    = err_q;

endmodule
